// File: rtl/coherency_pkg.sv
// Shared coherency bus definitions: core count, core-ID width
// and the bus request-type encoding.
package coherency_pkg;

    localparam int NUM_CORES = 4;
    localparam int CORE_ID_W = $clog2(NUM_CORES);

    typedef enum logic [1:0] {
        BUS_RD   = 2'b00,
        BUS_RDX  = 2'b01,
        BUS_UPGR = 2'b10,
        BUS_WB   = 2'b11
    } bus_req_e;

endpackage

// File: rtl/coherency_req_queue.sv
// Per-core miss/upgrade request FIFO feeding the coherency bus;
// duplicate requests already queued are absorbed instead of stored.
module coherency_req_queue
    import coherency_pkg::*;
#(
    parameter int CORE_ID    = 0,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enq_valid,
    input  logic [1:0]              enq_type,
    input  logic [ADDR_WIDTH-1:0]   enq_addr,
    output logic                    enq_ready,
    output logic                    req_valid,
    output logic [1:0]              req_type,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    bus_valid,
    input  logic [CORE_ID_W-1:0]    bus_granted_id,
    output logic                    merge_hit,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    grant_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [1:0]            type_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    logic granted;
    logic pop;
    logic offer;
    logic dup;
    logic push;

    assign enq_ready = (count != FULL);
    assign req_valid = (count != '0);
    assign req_type  = type_q[rd_ptr];
    assign req_addr  = addr_q[rd_ptr];

    assign granted = bus_valid && (bus_granted_id == CORE_ID_W'(CORE_ID));
    assign pop     = granted && req_valid;
    assign offer   = enq_valid && enq_ready;
    assign push    = offer && !dup;

    // A live slot lies within count entries of the head; the head
    // leaving this cycle cannot absorb a duplicate.
    always_comb begin
        dup = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (({1'b0, PW'(j) - rd_ptr} < count)
                && (type_q[j] == enq_type)
                && (addr_q[j] == enq_addr)
                && !(pop && (PW'(j) == rd_ptr)))
                dup = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            type_q[wr_ptr] <= enq_type;
            addr_q[wr_ptr] <= enq_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            merge_hit <= 1'b0;
            grant_err <= 1'b0;
        end else begin
            merge_hit <= offer && dup;
            if (granted && !req_valid)
                grant_err <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_coherency_req_queue.sv
// Directed bench for coherency_req_queue: reset, grant timing,
// full/backpressure, merge, simultaneous enq/pop, grant errors.
module tb_coherency_req_queue;
    import coherency_pkg::*;

    localparam int ID = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enq_valid;
    logic [1:0]  enq_type;
    logic [63:0] enq_addr;
    logic        enq_ready;
    logic        req_valid;
    logic [1:0]  req_type;
    logic [63:0] req_addr;
    logic        bus_valid;
    logic [1:0]  bus_granted_id;
    logic        merge_hit;
    logic [2:0]  count;
    logic        grant_err;

    int n_chk = 0;
    int n_err = 0;

    coherency_req_queue #(.CORE_ID(ID), .DEPTH(4), .ADDR_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .enq_valid(enq_valid), .enq_type(enq_type), .enq_addr(enq_addr),
        .enq_ready(enq_ready),
        .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr),
        .bus_valid(bus_valid), .bus_granted_id(bus_granted_id),
        .merge_hit(merge_hit), .count(count), .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [1:0] t, input logic [63:0] a);
        enq_valid = 1'b1;
        enq_type  = t;
        enq_addr  = a;
        cyc();
        enq_valid = 1'b0;
    endtask

    task automatic grant(input logic [1:0] id);
        bus_valid      = 1'b1;
        bus_granted_id = id;
        cyc();
        bus_valid      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enq_valid = 1'b0; enq_type = BUS_RD; enq_addr = '0;
        bus_valid = 1'b0; bus_granted_id = '0;
        #3;
        n_chk++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
        n_chk++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid got %b want 0", req_valid); end
        n_chk++; if (enq_ready !== 1'b1) begin n_err++; $display("FAIL rst_enq_ready got %b want 1", enq_ready); end
        n_chk++; if (merge_hit !== 1'b0) begin n_err++; $display("FAIL rst_merge_hit got %b want 0", merge_hit); end
        n_chk++; if (grant_err !== 1'b0) begin n_err++; $display("FAIL rst_grant_err got %b want 0", grant_err); end
        cyc();
        rst_n = 1'b1;
        enq(BUS_RD, 64'h100);
        n_chk++; if (count !== 3'd1) begin n_err++; $display("FAIL first_enq_count got %0d want 1", count); end
    endtask

    task automatic test_single_grant();
        bus_valid = 1'b1;
        bus_granted_id = 2'(ID);
        #1;
        n_chk++; if (req_addr !== 64'h100) begin n_err++; $display("FAIL grant_cycle_addr got %h want 100", req_addr); end
        n_chk++; if (req_valid !== 1'b1) begin n_err++; $display("FAIL grant_cycle_valid got %b want 1", req_valid); end
        n_chk++; if (count !== 3'd1) begin n_err++; $display("FAIL grant_cycle_count got %0d want 1", count); end
        @(posedge clk); #1;
        bus_valid = 1'b0;
        n_chk++; if (count !== 3'd0) begin n_err++; $display("FAIL post_grant_count got %0d want 0", count); end
        n_chk++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL post_grant_valid got %b want 0", req_valid); end
    endtask

    task automatic test_full();
        logic [63:0] exp_a [4];
        exp_a = '{64'h40, 64'h80, 64'hC0, 64'h100};
        enq(BUS_RD, 64'h0);
        enq(BUS_RD, 64'h40);
        enq(BUS_RD, 64'h80);
        enq(BUS_RD, 64'hC0);
        n_chk++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d want 4", count); end
        n_chk++; if (enq_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", enq_ready); end
        enq_valid = 1'b1; enq_type = BUS_RD; enq_addr = 64'h100;
        cyc();
        n_chk++; if (count !== 3'd4) begin n_err++; $display("FAIL held_offer_count got %0d want 4", count); end
        n_chk++; if (req_addr !== 64'h0) begin n_err++; $display("FAIL full_head got %h want 0", req_addr); end
        bus_valid = 1'b1; bus_granted_id = 2'(ID);
        #1;
        n_chk++; if (enq_ready !== 1'b0) begin n_err++; $display("FAIL full_pop_ready got %b want 0", enq_ready); end
        @(posedge clk); #1;
        bus_valid = 1'b0;
        n_chk++; if (count !== 3'd3) begin n_err++; $display("FAIL after_pop_count got %0d want 3", count); end
        n_chk++; if (enq_ready !== 1'b1) begin n_err++; $display("FAIL after_pop_ready got %b want 1", enq_ready); end
        cyc();
        enq_valid = 1'b0;
        n_chk++; if (count !== 3'd4) begin n_err++; $display("FAIL fifth_accept_count got %0d want 4", count); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (req_addr !== exp_a[i]) begin n_err++; $display("FAIL drain_order[%0d] got %h want %h", i, req_addr, exp_a[i]); end
            grant(2'(ID));
        end
        n_chk++; if (count !== 3'd0) begin n_err++; $display("FAIL drain_empty got %0d want 0", count); end
    endtask

    task automatic test_merge();
        logic [1:0]  exp_t [3];
        logic [63:0] exp_a [3];
        exp_t = '{BUS_RD, BUS_RDX, BUS_RD};
        exp_a = '{64'h180, 64'h200, 64'h200};
        enq(BUS_RD, 64'h180);
        enq(BUS_RDX, 64'h200);
        enq(BUS_RDX, 64'h200);
        n_chk++; if (merge_hit !== 1'b1) begin n_err++; $display("FAIL merge_pulse got %b want 1", merge_hit); end
        n_chk++; if (count !== 3'd2) begin n_err++; $display("FAIL merge_count got %0d want 2", count); end
        cyc();
        n_chk++; if (merge_hit !== 1'b0) begin n_err++; $display("FAIL merge_pulse_end got %b want 0", merge_hit); end
        enq(BUS_RD, 64'h200);
        n_chk++; if (count !== 3'd3) begin n_err++; $display("FAIL type_differs_count got %0d want 3", count); end
        n_chk++; if (merge_hit !== 1'b0) begin n_err++; $display("FAIL type_differs_merge got %b want 0", merge_hit); end
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (req_type !== exp_t[i] || req_addr !== exp_a[i])
                begin n_err++; $display("FAIL merge_order[%0d] got %0d/%h want %0d/%h", i, req_type, req_addr, exp_t[i], exp_a[i]); end
            grant(2'(ID));
        end
        // duplicate of the head leaving this cycle is stored, not merged
        enq(BUS_RD, 64'h500);
        enq_valid = 1'b1; enq_type = BUS_RD; enq_addr = 64'h500;
        bus_valid = 1'b1; bus_granted_id = 2'(ID);
        cyc();
        enq_valid = 1'b0; bus_valid = 1'b0;
        n_chk++; if (count !== 3'd1 || merge_hit !== 1'b0) begin n_err++; $display("FAIL head_pop_dup got %0d/%b want 1/0", count, merge_hit); end
        grant(2'(ID));
        n_chk++; if (count !== 3'd0) begin n_err++; $display("FAIL head_pop_dup_drain got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        enq(BUS_RD, 64'h280);
        enq(BUS_RD, 64'h290);
        enq_valid = 1'b1; enq_type = BUS_RD; enq_addr = 64'h300;
        bus_valid = 1'b1; bus_granted_id = 2'(ID);
        cyc();
        enq_valid = 1'b0; bus_valid = 1'b0;
        n_chk++; if (count !== 3'd2) begin n_err++; $display("FAIL b2b_count got %0d want 2", count); end
        n_chk++; if (req_addr !== 64'h290) begin n_err++; $display("FAIL b2b_head got %h want 290", req_addr); end
        grant(2'(ID));
        n_chk++; if (req_addr !== 64'h300) begin n_err++; $display("FAIL b2b_second got %h want 300", req_addr); end
        grant(2'(ID));
        n_chk++; if (count !== 3'd0) begin n_err++; $display("FAIL b2b_drain got %0d want 0", count); end
    endtask

    task automatic test_grant_err();
        grant(2'(ID));
        n_chk++; if (grant_err !== 1'b1) begin n_err++; $display("FAIL empty_grant_err got %b want 1", grant_err); end
        n_chk++; if (count !== 3'd0) begin n_err++; $display("FAIL empty_grant_count got %0d want 0", count); end
        enq(BUS_UPGR, 64'h380);
        grant(2'd2);
        n_chk++; if (count !== 3'd1) begin n_err++; $display("FAIL other_id_count got %0d want 1", count); end
        n_chk++; if (req_addr !== 64'h380 || req_type !== BUS_UPGR)
            begin n_err++; $display("FAIL other_id_head got %0d/%h want 2/380", req_type, req_addr); end
        n_chk++; if (grant_err !== 1'b1) begin n_err++; $display("FAIL grant_err_sticky got %b want 1", grant_err); end
    endtask

    task automatic test_mid_reset();
        enq(BUS_RD, 64'h3A0);
        enq(BUS_RD, 64'h3C0);
        n_chk++; if (count !== 3'd3) begin n_err++; $display("FAIL pre_reset_count got %0d want 3", count); end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (count !== 3'd0) begin n_err++; $display("FAIL mid_rst_count got %0d want 0", count); end
        n_chk++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b want 0", req_valid); end
        n_chk++; if (grant_err !== 1'b0) begin n_err++; $display("FAIL mid_rst_grant_err got %b want 0", grant_err); end
        n_chk++; if (enq_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready got %b want 1", enq_ready); end
        cyc();
        rst_n = 1'b1;
        enq(BUS_RD, 64'h400);
        n_chk++; if (req_addr !== 64'h400 || count !== 3'd1)
            begin n_err++; $display("FAIL post_rst_head got %h/%0d want 400/1", req_addr, count); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_grant();
        test_full();
        test_merge();
        test_back_to_back();
        test_grant_err();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
